// File: rtl/encoder_period_meter_pkg.sv
// Shared types and constants for the encoder period meter: period FSM states,
// direction encoding, default stall timeout and the quadrature phase table.
package encoder_period_meter_pkg;

   typedef enum logic [1:0] {
      IDLE       = 2'd0,
      WAIT_FIRST = 2'd1,
      MEASURE    = 2'd2,
      STALL      = 2'd3
   } period_state_e;

   localparam logic DIR_FWD = 1'b1;
   localparam logic DIR_REV = 1'b0;

   localparam int unsigned DEFAULT_TIMEOUT = 32'h0000_FFFF;

   // Index of a filtered {A,B} code along the forward cycle 00->10->11->01.
   function automatic logic [1:0] gray_phase(input logic [1:0] ab);
      logic [1:0] ph;
      case (ab)
         2'b00:   ph = 2'd0;
         2'b10:   ph = 2'd1;
         2'b11:   ph = 2'd2;
         default: ph = 2'd3;
      endcase
      return ph;
   endfunction

endpackage

// File: rtl/encoder_period_meter_input_filter.sv
// One encoder channel: synchroniser chain, agreement-count glitch filter and
// the post-reset init phase during which the filter tracks its input directly.
module encoder_input_filter #(
   parameter int SYNC_STAGES = 2,
   parameter int FILT_LEN    = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic raw_in,
   output logic filt_out,
   output logic init_active
);

   localparam int INIT_LEN = SYNC_STAGES + FILT_LEN;
   localparam int INIT_W   = $clog2(INIT_LEN + 1);

   logic [SYNC_STAGES-1:0] sync_q, sync_d;
   logic [3:0]             agree_cnt_q, agree_cnt_d;
   logic                   filt_q, filt_d;
   logic [INIT_W-1:0]      init_cnt_q, init_cnt_d;
   logic                   sync_val;

   assign sync_val    = sync_q[SYNC_STAGES-1];
   assign init_active = (init_cnt_q != INIT_W'(INIT_LEN));
   assign filt_out    = filt_q;

   always_comb begin
      sync_d      = {sync_q[SYNC_STAGES-2:0], raw_in};
      init_cnt_d  = init_active ? init_cnt_q + INIT_W'(1) : init_cnt_q;
      agree_cnt_d = '0;
      filt_d      = filt_q;
      if (init_active) begin
         filt_d = sync_val;
      end else if (sync_val != filt_q) begin
         // Toggle on the FILT_LEN-th consecutive disagreeing cycle.
         if (agree_cnt_q + 4'd1 == 4'(FILT_LEN)) begin
            filt_d = ~filt_q;
         end else begin
            agree_cnt_d = agree_cnt_q + 4'd1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         sync_q      <= '0;
         agree_cnt_q <= '0;
         filt_q      <= 1'b0;
         init_cnt_q  <= '0;
      end else begin
         sync_q      <= sync_d;
         agree_cnt_q <= agree_cnt_d;
         filt_q      <= filt_d;
         init_cnt_q  <= init_cnt_d;
      end
   end

endmodule

// File: rtl/encoder_period_meter.sv
// Quadrature encoder front end: x4 position/direction decode plus an
// A-rise-to-A-rise period meter with stall detection.
module encoder_period_meter
   import encoder_period_meter_pkg::*;
#(
   parameter int          SYNC_STAGES = 2,
   parameter int          FILT_LEN    = 4,
   parameter int          CNT_W       = 16,
   parameter int unsigned TIMEOUT     = DEFAULT_TIMEOUT
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             enable,
   input  logic             encoder_a,
   input  logic             encoder_b,
   output logic [CNT_W-1:0] period,
   output logic             period_valid,
   output logic             direction,
   output logic [15:0]      position,
   output logic             stalled,
   output logic             quad_error,
   output logic [1:0]       state_dbg
);

   localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);

   logic             filt_a, filt_b, init_a, init_b, init_active;
   logic [1:0]       cur_ab, prev_ab_q, prev_ab_d, phase_step;
   logic             step_fwd, step_rev, step_err, a_rise, timeout_hit;
   period_state_e    state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d, period_q, period_d;
   logic             period_valid_q, period_valid_d, stalled_q, stalled_d;
   logic             direction_q, direction_d, quad_error_q, quad_error_d;
   logic [15:0]      position_q, position_d;

   encoder_input_filter #(.SYNC_STAGES(SYNC_STAGES), .FILT_LEN(FILT_LEN)) u_filt_a (
      .clk(clk), .rst(rst), .raw_in(encoder_a), .filt_out(filt_a), .init_active(init_a)
   );

   encoder_input_filter #(.SYNC_STAGES(SYNC_STAGES), .FILT_LEN(FILT_LEN)) u_filt_b (
      .clk(clk), .rst(rst), .raw_in(encoder_b), .filt_out(filt_b), .init_active(init_b)
   );

   assign init_active = init_a | init_b;

   // Decode on previous vs current filtered code; a phase jump of 2 means both pins moved.
   always_comb begin
      cur_ab       = {filt_a, filt_b};
      prev_ab_d    = cur_ab;
      phase_step   = gray_phase(cur_ab) - gray_phase(prev_ab_q);
      step_fwd     = !init_active && (phase_step == 2'd1);
      step_rev     = !init_active && (phase_step == 2'd3);
      step_err     = !init_active && (phase_step == 2'd2);
      a_rise       = !init_active && filt_a && !prev_ab_q[1];
      position_d   = position_q;
      direction_d  = direction_q;
      quad_error_d = step_err;
      if (step_fwd) begin
         position_d  = position_q + 16'd1;
         direction_d = DIR_FWD;
      end else if (step_rev) begin
         position_d  = position_q - 16'd1;
         direction_d = DIR_REV;
      end
   end

   assign timeout_hit = (cnt_q == TIMEOUT_C);

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      if (!enable) begin
         state_d = IDLE;
      end else begin
         case (state_q)
            IDLE:       state_d = WAIT_FIRST;
            WAIT_FIRST: if (a_rise) state_d = MEASURE;
            MEASURE:    if (!a_rise && timeout_hit) state_d = STALL;
            STALL:      if (a_rise) state_d = MEASURE;
            default:    state_d = IDLE;
         endcase
      end
   end

   // cnt_q already holds the cycles elapsed since the previous A edge-detect cycle.
   always_comb begin
      cnt_d          = cnt_q;
      period_d       = period_q;
      period_valid_d = 1'b0;
      stalled_d      = stalled_q;
      if (!enable) begin
         cnt_d     = '0;
         stalled_d = 1'b0;
      end else begin
         case (state_q)
            IDLE: cnt_d = '0;
            WAIT_FIRST: if (a_rise) cnt_d = CNT_W'(1);
            MEASURE: begin
               if (a_rise) begin
                  period_d       = cnt_q;
                  cnt_d          = CNT_W'(1);
                  period_valid_d = 1'b1;
                  stalled_d      = 1'b0;
               end else if (timeout_hit) begin
                  period_d       = TIMEOUT_C;
                  cnt_d          = '0;
                  period_valid_d = 1'b1;
                  stalled_d      = 1'b1;
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
            STALL: if (a_rise) cnt_d = CNT_W'(1);
            default: cnt_d = '0;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         prev_ab_q      <= '0;
         position_q     <= '0;
         direction_q    <= 1'b0;
         quad_error_q   <= 1'b0;
         cnt_q          <= '0;
         period_q       <= '0;
         period_valid_q <= 1'b0;
         stalled_q      <= 1'b0;
      end else begin
         prev_ab_q      <= prev_ab_d;
         position_q     <= position_d;
         direction_q    <= direction_d;
         quad_error_q   <= quad_error_d;
         cnt_q          <= cnt_d;
         period_q       <= period_d;
         period_valid_q <= period_valid_d;
         stalled_q      <= stalled_d;
      end
   end

   assign period       = period_q;
   assign period_valid = period_valid_q;
   assign direction    = direction_q;
   assign position     = position_q;
   assign stalled      = stalled_q;
   assign quad_error   = quad_error_q;
   assign state_dbg    = state_q;

endmodule

// File: tb/tb_encoder_period_meter.sv
// Bench for encoder_period_meter: pin-level reference model, step table,
// hand sequences for stall/glitch/reset, and a position wrap run on a fast instance.
`timescale 1ns/1ps
module tb_encoder_period_meter;
   import encoder_period_meter_pkg::*;

   localparam int SYNC_STAGES = 2;
   localparam int FILT_LEN    = 4;
   localparam int CNT_W       = 16;
   localparam int TIMEOUT_I   = 256;
   localparam int LAT         = SYNC_STAGES + FILT_LEN;
   localparam int EW          = CNT_W + 1;
   localparam logic [1:0] FWD_SEQ [4] = '{2'b00, 2'b10, 2'b11, 2'b01};

   // ---------------- clock / reset / DUTs ----------------
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic             rst, enable, encoder_a, encoder_b;
   logic [CNT_W-1:0] period;
   logic             period_valid, direction, stalled, quad_error;
   logic [15:0]      position;
   logic [1:0]       state_dbg;

   encoder_period_meter #(
      .SYNC_STAGES(SYNC_STAGES), .FILT_LEN(FILT_LEN), .CNT_W(CNT_W), .TIMEOUT(TIMEOUT_I)
   ) dut (
      .clk(clk), .rst(rst), .enable(enable), .encoder_a(encoder_a), .encoder_b(encoder_b),
      .period(period), .period_valid(period_valid), .direction(direction),
      .position(position), .stalled(stalled), .quad_error(quad_error), .state_dbg(state_dbg)
   );

   logic        w_rst, w_a, w_b;
   logic [15:0] w_period, w_position;
   logic        w_pv, w_dir, w_stalled, w_qerr;
   logic [1:0]  w_state;

   encoder_period_meter #(.SYNC_STAGES(2), .FILT_LEN(1), .CNT_W(16)) dut_wrap (
      .clk(clk), .rst(w_rst), .enable(1'b0), .encoder_a(w_a), .encoder_b(w_b),
      .period(w_period), .period_valid(w_pv), .direction(w_dir),
      .position(w_position), .stalled(w_stalled), .quad_error(w_qerr), .state_dbg(w_state)
   );

   // ---------------- scoreboard ----------------
   int errors = 0;
   int checks = 0;
   logic [EW-1:0] exp_q[$];
   logic [EW-1:0] exp_item;
   int pv_count = 0, qerr_count = 0, w_qerr_count = 0;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, want);
      end
   endtask

   always @(posedge clk) begin
      #1;
      if (period_valid) begin
         pv_count++;
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_period_valid: got period=%0d stalled=%0b, none expected",
                     period, stalled);
         end else begin
            exp_item = exp_q.pop_front();
            check("period_at_valid", 32'(period), 32'(exp_item[CNT_W-1:0]));
            check("stalled_at_valid", 32'(stalled), 32'(exp_item[CNT_W]));
         end
      end
      if (quad_error) qerr_count++;
      if (w_qerr) w_qerr_count++;
   end

   // ---------------- reference model (pin-level, cycle-indexed) ----------------
   int   n = 0;
   logic m_a, m_b, m_dir, glitch_on;
   int   m_pos, m_qerr, m_mode, m_last, m_last_period;

   function automatic int phase_of(input logic a, input logic b);
      for (int i = 0; i < 4; i++) if (FWD_SEQ[i] == {a, b}) return i;
      return 0;
   endfunction

   task automatic push_exp(input int p, input logic st);
      exp_q.push_back({st, CNT_W'(p)});
      m_last_period = p;
   endtask

   task automatic cycle(input logic a, input logic b);
      logic ma, mb, rise;
      int   d;
      @(negedge clk);
      encoder_a = a;
      encoder_b = b;
      n++;
      ma = glitch_on ? m_a : a;
      mb = glitch_on ? m_b : b;
      if ({ma, mb} != {m_a, m_b}) begin
         d = (phase_of(ma, mb) - phase_of(m_a, m_b) + 4) % 4;
         if (d == 1) begin m_pos++; m_dir = 1'b1; end
         else if (d == 3) begin m_pos--; m_dir = 1'b0; end
         else m_qerr++;
      end
      rise = ma & ~m_a;
      m_a  = ma;
      m_b  = mb;
      if (rst || !enable) begin
         m_mode = 0;
      end else begin
         case (m_mode)
            0: if (rise) begin m_mode = 1; m_last = n; end
            1: begin
               if (rise) begin push_exp(n - m_last, 1'b0); m_last = n; end
               else if (n - m_last == TIMEOUT_I) begin push_exp(TIMEOUT_I, 1'b1); m_mode = 2; end
            end
            default: if (rise) begin m_mode = 1; m_last = n; end
         endcase
      end
   endtask

   // ---------------- driver tasks ----------------
   task automatic idle(input int k);
      repeat (k) cycle(encoder_a, encoder_b);
   endtask

   task automatic quad_steps(input int count, input logic fwd, input int gap_lo, input int gap_hi);
      logic [1:0] nxt;
      int ph, g;
      for (int i = 0; i < count; i++) begin
         ph  = phase_of(encoder_a, encoder_b);
         nxt = FWD_SEQ[(ph + (fwd ? 1 : 3)) % 4];
         g   = $urandom_range(gap_hi, gap_lo);
         cycle(nxt[1], nxt[0]);
         idle(g - 1);
      end
   endtask

   task automatic glitch_a();
      logic a0, b0;
      a0 = encoder_a;
      b0 = encoder_b;
      glitch_on = 1'b1;
      cycle(~a0, b0);
      cycle(~a0, b0);
      cycle(a0, b0);
      glitch_on = 1'b0;
   endtask

   task automatic do_reset(input string tag);
      rst = 1'b1;
      repeat (3) cycle(encoder_a, encoder_b);
      check({tag, "_period"}, 32'(period), 32'd0);
      check({tag, "_period_valid"}, 32'(period_valid), 32'd0);
      check({tag, "_direction"}, 32'(direction), 32'd0);
      check({tag, "_position"}, 32'(position), 32'd0);
      check({tag, "_stalled"}, 32'(stalled), 32'd0);
      check({tag, "_quad_error"}, 32'(quad_error), 32'd0);
      check({tag, "_state"}, 32'(state_dbg), 32'(IDLE));
      rst   = 1'b0;
      m_pos = 0;
      m_dir = 1'b0;
      m_mode = 0;
   endtask

   task automatic check_state(input string tag);
      idle(LAT + 4);
      check({tag, "_position"}, 32'(position), 32'(16'(m_pos)));
      check({tag, "_direction"}, 32'(direction), 32'(m_dir));
      check({tag, "_quad_errors"}, 32'(qerr_count), 32'(m_qerr));
   endtask

   // ---------------- step table ----------------
   typedef struct {
      logic a;
      logic b;
      int   pos;
      logic dir;
      int   qerr;
   } vec_t;
   vec_t tbl [9];

   initial begin
      #3_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int pv0, q0;
      tbl[0] = '{1'b0, 1'b1, 1, 1'b1, 0};
      tbl[1] = '{1'b0, 1'b0, 2, 1'b1, 0};
      tbl[2] = '{1'b1, 1'b0, 3, 1'b1, 0};
      tbl[3] = '{1'b0, 1'b0, 2, 1'b0, 0};
      tbl[4] = '{1'b0, 1'b1, 1, 1'b0, 0};
      tbl[5] = '{1'b1, 1'b0, 1, 1'b0, 1};
      tbl[6] = '{1'b1, 1'b1, 2, 1'b1, 0};
      tbl[7] = '{1'b0, 1'b0, 2, 1'b1, 1};
      tbl[8] = '{1'b0, 1'b1, 1, 1'b0, 0};

      rst = 1'b1; enable = 1'b0; encoder_a = 1'b1; encoder_b = 1'b1;
      w_rst = 1'b1; w_a = 1'b0; w_b = 1'b0;
      glitch_on = 1'b0;
      m_a = 1'b1; m_b = 1'b1; m_dir = 1'b0;
      m_pos = 0; m_qerr = 0; m_mode = 0; m_last = 0; m_last_period = 0;

      // Reset with both pins high: nothing may happen through init and after.
      do_reset("reset");
      idle(LAT + 20);
      check("init_no_period_valid", 32'(pv_count), 32'd0);
      check("init_no_quad_error", 32'(qerr_count), 32'd0);
      check("init_position", 32'(position), 32'd0);

      // Single steps and illegal jumps, measurement disabled.
      foreach (tbl[i]) begin
         q0 = qerr_count;
         cycle(tbl[i].a, tbl[i].b);
         idle(LAT + 4);
         check($sformatf("tbl%0d_position", i), 32'(position), 32'(16'(tbl[i].pos)));
         check($sformatf("tbl%0d_direction", i), 32'(direction), 32'(tbl[i].dir));
         check($sformatf("tbl%0d_quad_error_pulses", i), 32'(qerr_count - q0), 32'(tbl[i].qerr));
      end

      // Forward 200-cycle square wave, then random forward gaps.
      enable = 1'b1;
      idle(10);
      quad_steps(16, 1'b1, 50, 50);
      check_state("fwd_fixed");
      check("fwd_fixed_period", 32'(period), 32'd200);
      quad_steps(24, 1'b1, FILT_LEN + 2, 55);
      check_state("fwd_random");

      // Glitch on A shorter than the filter.
      quad_steps(4, 1'b1, 50, 50);
      pv0 = pv_count;
      glitch_a();
      idle(20);
      check("glitch_no_period_valid", 32'(pv_count), 32'(pv0));
      check_state("glitch");

      // Stall on a static A, then recovery.
      idle(300);
      check("stall_flag", 32'(stalled), 32'd1);
      check("stall_period", 32'(period), 32'(TIMEOUT_I));
      check("stall_state", 32'(state_dbg), 32'(STALL));
      quad_steps(4, 1'b1, 50, 50);
      check("stall_held_after_first_rise", 32'(stalled), 32'd1);
      quad_steps(4, 1'b1, 50, 50);
      check("stall_cleared", 32'(stalled), 32'd0);
      check("stall_recover_period", 32'(period), 32'd200);

      // Reverse rotation.
      quad_steps(16, 1'b0, 50, 50);
      check_state("rev_fixed");
      check("rev_fixed_period", 32'(period), 32'd200);
      quad_steps(20, 1'b0, FILT_LEN + 2, 55);
      check_state("rev_random");

      // Reset in the middle of a measurement.
      quad_steps(4, 1'b0, 50, 50);
      pv0 = pv_count;
      do_reset("mid_reset");
      idle(LAT + 10);
      check("mid_reset_position", 32'(position), 32'd0);
      quad_steps(4, 1'b1, 50, 50);
      check("mid_reset_first_rise_silent", 32'(pv_count), 32'(pv0));
      quad_steps(4, 1'b1, 50, 50);
      check("mid_reset_second_rise_valid", 32'(pv_count), 32'(pv0 + 1));
      check("mid_reset_period", 32'(period), 32'd200);
      check_state("mid_reset");

      // Disable: back to IDLE, period held, no stall.
      enable = 1'b0;
      idle(5);
      check("disable_state", 32'(state_dbg), 32'(IDLE));
      check("disable_period_hold", 32'(period), 32'(m_last_period));
      idle(300);
      check("disable_no_stall", 32'(stalled), 32'd0);
      check("pending_expected_periods", 32'(exp_q.size()), 32'd0);

      // Position wrap on the fast instance (FILT_LEN=1, one step per cycle).
      repeat (5) @(negedge clk);
      w_rst = 1'b0;
      repeat (10) @(negedge clk);
      for (int i = 0; i < 32768; i++) begin
         logic [1:0] nx;
         nx = FWD_SEQ[(phase_of(w_a, w_b) + 3) % 4];
         @(negedge clk);
         w_a = nx[1];
         w_b = nx[0];
      end
      repeat (10) @(negedge clk);
      check("wrap_min_position", 32'(w_position), 32'h8000);
      check("wrap_min_direction", 32'(w_dir), 32'd0);
      begin
         logic [1:0] nx;
         nx = FWD_SEQ[(phase_of(w_a, w_b) + 3) % 4];
         @(negedge clk);
         w_a = nx[1];
         w_b = nx[0];
         repeat (10) @(negedge clk);
         check("wrap_rev_position", 32'(w_position), 32'h7FFF);
         nx = FWD_SEQ[(phase_of(w_a, w_b) + 1) % 4];
         @(negedge clk);
         w_a = nx[1];
         w_b = nx[0];
         repeat (10) @(negedge clk);
         check("wrap_fwd_position", 32'(w_position), 32'h8000);
         check("wrap_fwd_direction", 32'(w_dir), 32'd1);
      end
      check("wrap_no_quad_error", 32'(w_qerr_count), 32'd0);
      check("wrap_idle_outputs", 32'({w_period, w_pv, w_stalled, w_state}), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
